// File: rtl/avl_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM memory arbiter.
package avl_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  localparam logic [31:0] ARB_ERR_READDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] address;
    logic                  read;
    logic                  write;
    logic [ARB_DATA_W-1:0] writedata;
    logic [ARB_BE_W-1:0]   byteenable;
  } master_req_t;

  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      GNT0:    grant_of = 2'b01;
      GNT1:    grant_of = 2'b10;
      default: grant_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/avl_arb_stall_timer.sv
// Stall watchdog for the arbiter: down-counter reloaded on every new grant,
// flags the cycle on which the slave has stalled TIMEOUT_CYCLES times in a row.
module avl_arb_stall_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic stall,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = CNT_LOAD;
    end else if (stall && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Terminal count is hit on the stall cycle that finds the counter at zero.
  assign expired = stall && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/avl_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM RAM between instruction (m0) and
// data (m1) masters. Define AVL_ARB_TIMEOUT_EN to add the slave stall watchdog.
//
// state | meaning
// IDLE  | no owner, slave sees zeros, both masters stalled
// GNT0  | m0 routed to slave until it completes or drops its request
// GNT1  | m1 routed to slave until it completes or drops its request
module avl_mem_arbiter
  import avl_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant
`ifdef AVL_ARB_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  arb_state_t  state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 0 = m0 served last, 1 = m1
  logic [1:0]  grant_q, grant_d;
  master_req_t req0, req1, sel;
  logic        req0_vld, req1_vld;
  logic        tmo_hit;

  always_comb begin
    req0.address    = ARB_ADDR_W'(m0_address);
    req0.read       = m0_read;
    req0.write      = m0_write;
    req0.writedata  = ARB_DATA_W'(m0_writedata);
    req0.byteenable = ARB_BE_W'(m0_byteenable);
    req1.address    = ARB_ADDR_W'(m1_address);
    req1.read       = m1_read;
    req1.write      = m1_write;
    req1.writedata  = ARB_DATA_W'(m1_writedata);
    req1.byteenable = ARB_BE_W'(m1_byteenable);
  end

  assign req0_vld = m0_read | m0_write;
  assign req1_vld = m1_read | m1_write;

`ifdef AVL_ARB_TIMEOUT_EN
  logic tmr_restart;

  assign tmr_restart = (state_q == IDLE) || (state_d != state_q);

  avl_arb_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (tmr_restart),
    .stall   (s_waitrequest && (state_q != IDLE)),
    .expired (tmo_hit)
  );

  assign timeout_err = tmo_hit;
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (req0_vld && req1_vld) begin
          state_d = last_grant_q ? GNT0 : GNT1;
        end else if (req0_vld) begin
          state_d = GNT0;
        end else if (req1_vld) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!req0_vld) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          last_grant_d = 1'b0;
          state_d      = IDLE;
        end else if (!s_waitrequest) begin
          // Hand straight over to a waiting m1 so alternation costs no idle cycle.
          last_grant_d = 1'b0;
          state_d      = req1_vld ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!req1_vld) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          last_grant_d = 1'b1;
          state_d      = IDLE;
        end else if (!s_waitrequest) begin
          last_grant_d = 1'b1;
          state_d      = req0_vld ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = grant_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
    end
  end

  assign grant = grant_q;

  always_comb begin
    sel            = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    case (state_q)
      GNT0: begin
        sel            = req0;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
        if (tmo_hit) begin
          m0_waitrequest = 1'b0;
          m0_readdata    = DATA_W'(ARB_ERR_READDATA);
        end
      end
      GNT1: begin
        sel            = req1;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
        if (tmo_hit) begin
          m1_waitrequest = 1'b0;
          m1_readdata    = DATA_W'(ARB_ERR_READDATA);
        end
      end
      default: ;
    endcase
  end

  // A master driving read and write together gets only the write forwarded.
  assign s_address    = ADDR_W'(sel.address);
  assign s_read       = sel.read & ~sel.write;
  assign s_write      = sel.write;
  assign s_writedata  = DATA_W'(sel.writedata);
  assign s_byteenable = (DATA_W/8)'(sel.byteenable);

  a_m0_rw_excl: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write))
    else $error("m0 read and write asserted together");
  a_m1_rw_excl: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write))
    else $error("m1 read and write asserted together");

endmodule

// File: tb/tb_avl_mem_arbiter.sv
// Directed bench for avl_mem_arbiter with a behavioural zero/N-wait RAM.
// Build with AVL_ARB_TIMEOUT_EN defined to also exercise the stall watchdog.
module tb_avl_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic [1:0]  grant;
`ifdef AVL_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  avl_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
`ifdef AVL_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .grant(grant)
  );

  // RAM model: stalls each access for ram_wait cycles, or forever with ram_stuck.
  logic [31:0] mem [0:2047];
  int unsigned wcnt = 0;
  int unsigned ram_wait = 0;
  logic        ram_stuck = 1'b0;
  logic        load_en;

  assign s_waitrequest = ram_stuck || ((s_read || s_write) && (wcnt < ram_wait));
  assign s_readdata    = mem[s_address[12:2]];

  always @(posedge clk) begin
    if (load_en) begin
      mem[1]    <= 32'h2404FFFF;
      mem[2]    <= 32'hA5A50008;
      mem[1024] <= 32'h0;
    end else if (s_read || s_write) begin
      if (s_waitrequest) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        if (s_write) mem[s_address[12:2]] <= s_writedata;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_en = 1'b1;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 4'hF;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 4'hF;
    next_cycle();
    next_cycle();
    reset = 1'b0; load_en = 1'b0;

    // Reset state
    @(negedge clk);
    check_val("rst_grant", grant, 2'b00);
    check_val("rst_s_read", s_read, 0);
    check_val("rst_s_write", s_write, 0);
    check_val("rst_s_address", s_address, 0);
    check_val("rst_s_be", s_byteenable, 0);
    check_val("rst_m0_wait", m0_waitrequest, 1);
    check_val("rst_m1_wait", m1_waitrequest, 1);
    check_val("rst_m0_rdata", m0_readdata, 0);

    // Single m0 read of 0x04, zero-wait RAM
    next_cycle();
    m0_read = 1; m0_address = 32'h4;
    @(negedge clk);
    check_val("t1_arb_grant", grant, 2'b00);
    check_val("t1_arb_m0_wait", m0_waitrequest, 1);
    next_cycle();
    @(negedge clk);
    check_val("t1_grant", grant, 2'b01);
    check_val("t1_m0_wait", m0_waitrequest, 0);
    check_val("t1_m0_rdata", m0_readdata, 32'h2404FFFF);
    check_val("t1_s_read", s_read, 1);
    check_val("t1_s_address", s_address, 32'h4);
    check_val("t1_m1_wait", m1_waitrequest, 1);
    next_cycle();
    m0_read = 0;
    @(negedge clk);
    check_val("t1_done_grant", grant, 2'b00);
    check_val("t1_done_m0_wait", m0_waitrequest, 1);

    // Simultaneous m0 read and m1 write after reset: m0 first, m1 right after
    next_cycle();
    do_reset();
    m0_read = 1; m0_address = 32'h8;
    m1_write = 1; m1_address = 32'h1000; m1_writedata = 32'hCAFEF00D;
    @(negedge clk);
    check_val("t2_arb_grant", grant, 2'b00);
    next_cycle();
    @(negedge clk);
    check_val("t2_g0_grant", grant, 2'b01);
    check_val("t2_g0_m0_wait", m0_waitrequest, 0);
    check_val("t2_g0_m0_rdata", m0_readdata, 32'hA5A50008);
    check_val("t2_g0_m1_wait", m1_waitrequest, 1);
    next_cycle();
    m0_read = 0;
    @(negedge clk);
    check_val("t2_g1_grant", grant, 2'b10);
    check_val("t2_g1_s_write", s_write, 1);
    check_val("t2_g1_s_read", s_read, 0);
    check_val("t2_g1_s_address", s_address, 32'h1000);
    check_val("t2_g1_s_wdata", s_writedata, 32'hCAFEF00D);
    check_val("t2_g1_m1_wait", m1_waitrequest, 0);
    check_val("t2_g1_m0_wait", m0_waitrequest, 1);
    next_cycle();
    m1_write = 0;
    m0_read = 1; m0_address = 32'h1000;
    @(negedge clk);
    check_val("t2_rb_arb_grant", grant, 2'b00);
    next_cycle();
    @(negedge clk);
    check_val("t2_rb_grant", grant, 2'b01);
    check_val("t2_rb_m0_wait", m0_waitrequest, 0);
    check_val("t2_rb_m0_rdata", m0_readdata, 32'hCAFEF00D);
    next_cycle();
    m0_read = 0;

    // Both masters request continuously: 10 strictly alternating grants
    do_reset();
    m0_read = 1; m0_address = 32'h4;
    m1_read = 1; m1_address = 32'h8;
    @(negedge clk);
    check_val("t3_arb_grant", grant, 2'b00);
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if (k == 9) m0_read = 0;
      @(negedge clk);
      check_val("t3_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      check_val("t3_m0_wait", m0_waitrequest, (k % 2 == 0) ? 1'b0 : 1'b1);
      check_val("t3_m1_wait", m1_waitrequest, (k % 2 == 0) ? 1'b1 : 1'b0);
    end
    next_cycle();
    m1_read = 0;
    @(negedge clk);
    check_val("t3_done_grant", grant, 2'b00);

    // RAM stalls 3 cycles on an m1 read; m0 waits behind it
    next_cycle();
    m1_read = 1; m1_address = 32'h4; ram_wait = 3;
    @(negedge clk);
    check_val("t4_arb_grant", grant, 2'b00);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      m0_read = 1; m0_address = 32'h8;
      @(negedge clk);
      check_val("t4_grant", grant, 2'b10);
      check_val("t4_m1_wait", m1_waitrequest, (i < 3) ? 1'b1 : 1'b0);
      check_val("t4_m0_wait", m0_waitrequest, 1);
    end
    check_val("t4_m1_rdata", m1_readdata, 32'h2404FFFF);
    next_cycle();
    m1_read = 0; ram_wait = 0;
    @(negedge clk);
    check_val("t4_m0_grant", grant, 2'b01);
    check_val("t4_m0_wait_done", m0_waitrequest, 0);
    check_val("t4_m0_rdata", m0_readdata, 32'hA5A50008);
    next_cycle();
    m0_read = 0;

    // Reset while GNT1 is stalled, then m1 retries
    m1_read = 1; m1_address = 32'h8; ram_wait = 5;
    @(negedge clk);
    check_val("t5_arb_grant", grant, 2'b00);
    next_cycle();
    @(negedge clk);
    check_val("t5_g1_grant", grant, 2'b10);
    check_val("t5_g1_m1_wait", m1_waitrequest, 1);
    next_cycle();
    reset = 1;
    @(negedge clk);
    check_val("t5_rst_s_read_held", s_read, 1);
    next_cycle();
    reset = 0; ram_wait = 0;
    @(negedge clk);
    check_val("t5_post_rst_grant", grant, 2'b00);
    check_val("t5_post_rst_s_read", s_read, 0);
    check_val("t5_post_rst_m1_wait", m1_waitrequest, 1);
    next_cycle();
    @(negedge clk);
    check_val("t5_retry_grant", grant, 2'b10);
    check_val("t5_retry_m1_wait", m1_waitrequest, 0);
    check_val("t5_retry_m1_rdata", m1_readdata, 32'hA5A50008);
    next_cycle();
    m1_read = 0;
    @(negedge clk);
    check_val("t5_done_grant", grant, 2'b00);

`ifdef AVL_ARB_TIMEOUT_EN
    // Stuck RAM: watchdog releases m0 on the 8th stall cycle
    next_cycle();
    do_reset();
    ram_stuck = 1;
    m0_read = 1; m0_address = 32'h4;
    @(negedge clk);
    check_val("t6_arb_grant", grant, 2'b00);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      @(negedge clk);
      check_val("t6_grant", grant, 2'b01);
      check_val("t6_m0_wait", m0_waitrequest, (i < 7) ? 1'b1 : 1'b0);
      check_val("t6_timeout_err", timeout_err, (i == 7) ? 1'b1 : 1'b0);
      if (i == 7) check_val("t6_m0_rdata", m0_readdata, 32'hDEADBEEF);
    end
    next_cycle();
    m0_read = 0; ram_stuck = 0;
    @(negedge clk);
    check_val("t6_after_grant", grant, 2'b00);
    check_val("t6_after_err", timeout_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
